// File: rtl/adder_result_accumulator.sv
// -----------------------------------------------------------------------------
// adder_result_accumulator
//
// Purpose:
//   Sits downstream of the ripple-carry adder stage. Each accepted adder result
//   {carry, sum} is zero-extended and added into an ACC_WIDTH-bit accumulator.
//   After COUNT results the block total, together with a sticky overflow flag,
//   is offered on a valid/ready output port. While the total is pending the
//   input side is stalled through in_ready, which gives the adder path the
//   backpressure it otherwise lacks.
//
// Build option:
//   ACC_SATURATE_EN  defined   -> on overflow the accumulator clamps to all-ones
//                                 and stays there for the rest of the block.
//                    undefined -> on overflow the accumulator wraps modulo
//                                 2^ACC_WIDTH (default).
//   The overflow flag is sticky within a block in both builds.
//
// Parameters:
//   DATA_WIDTH  width of the adder sum
//   ACC_WIDTH   accumulator width, at least DATA_WIDTH+1
//   COUNT       adder results per block, at least 1
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   clear         synchronous abort of the current block (discards pending total)
//   in_valid      upstream result valid
//   in_ready      block can accept a result (depends on state only)
//   in_sum        adder sum
//   in_carry      adder carry-out
//   out_valid     block total valid
//   out_ready     downstream accepts the total
//   out_acc       block total (running accumulator value between blocks)
//   out_overflow  total exceeded ACC_WIDTH bits at some point during the block
// -----------------------------------------------------------------------------
module adder_result_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int COUNT      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_sum,
  input  logic                  in_carry,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_acc,
  output logic                  out_overflow
);

  localparam int CNT_WIDTH = $clog2(COUNT + 1);
  // The accept that arrives while the counter holds this value completes a block.
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(COUNT - 1);

  generate
    if (ACC_WIDTH < DATA_WIDTH + 1) begin : g_bad_acc_width
      $error("adder_result_accumulator: ACC_WIDTH must be >= DATA_WIDTH+1");
    end
    if (COUNT < 1) begin : g_bad_count
      $error("adder_result_accumulator: COUNT must be >= 1");
    end
  endgenerate

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_t;

  state_t                 state_reg, state_next;
  logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
  logic [CNT_WIDTH-1:0]   count_reg, count_next;
  logic                   ovf_reg, ovf_next;

  // One extra bit so the carry out of the accumulator is visible.
  logic [ACC_WIDTH:0]     operand;
  logic [ACC_WIDTH:0]     sum_ext;

  assign operand = (ACC_WIDTH + 1)'({in_carry, in_sum});
  assign sum_ext = {1'b0, acc_reg} + operand;

  // Handshake outputs follow the state register only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready     = (state_reg == ACCUM);
  assign out_valid    = (state_reg == OUTPUT);
  assign out_acc      = acc_reg;
  assign out_overflow = ovf_reg;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;

    if (clear) begin
      // Abort wins over any handshake in the same cycle.
      state_next = ACCUM;
      acc_next   = '0;
      count_next = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (in_valid) begin
            count_next = count_reg + CNT_WIDTH'(1);
            ovf_next   = ovf_reg | sum_ext[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
            // Once the block has overflowed the accumulator stays pinned at
            // all-ones, even if later operands are zero.
            if (sum_ext[ACC_WIDTH] || ovf_reg) begin
              acc_next = '1;
            end else begin
              acc_next = sum_ext[ACC_WIDTH-1:0];
            end
`else
            acc_next   = sum_ext[ACC_WIDTH-1:0];
`endif
            if (count_reg == LAST_COUNT) begin
              state_next = OUTPUT;
            end
          end
        end

        OUTPUT: begin
          if (out_ready) begin
            state_next = ACCUM;
            acc_next   = '0;
            count_next = '0;
            ovf_next   = 1'b0;
          end
        end

        default: begin
          state_next = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ACCUM;
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

endmodule
